// File: rtl/lsb_extract_ctrl.sv
// rtl/lsb_extract_ctrl.sv - LSB-steganography extraction sequencer with bottom-up row addressing and valid/ready byte output
module lsb_extract_ctrl #(
    parameter int WIDTH  = 500,
    parameter int HEIGHT = 332,
    parameter int ADDR_W = 20,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              HRESETn,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  msg_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        msg_data,
    output logic              msg_valid,
    input  logic              msg_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int ROW_BYTES = 3 * WIDTH;
    localparam int TOTAL     = ROW_BYTES * HEIGHT;

    localparam logic [ADDR_W-1:0] ROW_STEP      = ADDR_W'(ROW_BYTES);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(ROW_BYTES * (HEIGHT - 1));
    localparam logic [ADDR_W-1:0] TOTAL_P       = ADDR_W'(TOTAL);
    localparam logic [ADDR_W-1:0] OFF_LAST      = ADDR_W'(ROW_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_EMIT,
        S_FIN
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [10:0]        acc;
    logic [3:0]         nb;
    logic [LEN_W-1:0]   byte_cnt;
    logic [LEN_W-1:0]   len_q;
    logic [ADDR_W-1:0]  p;
    logic [ADDR_W-1:0]  offset;
    logic [ADDR_W-1:0]  row_base;
    logic               err_q;

    logic [3:0]         nb_cap;
    logic [10:0]        acc_cap;
    logic               last_byte;
    logic               overflow;
    logic               unused_rd_hi;

    assign nb_cap       = nb + 4'd3;
    assign acc_cap      = acc | ({8'b0, mem_rd_data[2:0]} << nb);
    assign last_byte    = (byte_cnt + LEN_W'(1)) == len_q;
    assign overflow     = (p == TOTAL_P);
    assign unused_rd_hi = &{1'b0, mem_rd_data[7:3]};

    // Rows are stored bottom-up, so the display row walks memory downwards
    assign mem_addr = row_base + offset;
    assign msg_data = acc[7:0];
    assign err      = err_q;

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        mem_rd_en = 1'b0;
        msg_valid = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = (msg_len == '0) ? S_FIN : S_RD;
                end
            end
            S_RD: begin
                if (overflow) begin
                    state_n = S_FIN;
                end else begin
                    mem_rd_en = 1'b1;
                    state_n   = S_CAP;
                end
            end
            S_CAP: begin
                state_n = (nb_cap >= 4'd8) ? S_EMIT : S_RD;
            end
            S_EMIT: begin
                msg_valid = 1'b1;
                if (msg_ready) begin
                    state_n = last_byte ? S_FIN : S_RD;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // Abort wins over everything, including a read about to issue
        if (abort) begin
            state_n   = S_IDLE;
            mem_rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            acc      <= '0;
            nb       <= '0;
            byte_cnt <= '0;
            len_q    <= '0;
            p        <= '0;
            offset   <= '0;
            row_base <= '0;
            err_q    <= 1'b0;
        end else if (!abort) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_q    <= 1'b0;
                        len_q    <= msg_len;
                        acc      <= '0;
                        nb       <= '0;
                        byte_cnt <= '0;
                        p        <= '0;
                        offset   <= '0;
                        row_base <= LAST_ROW_BASE;
                    end
                end
                S_RD: begin
                    if (overflow) begin
                        err_q <= 1'b1;
                    end else begin
                        p <= p + ADDR_W'(1);
                        if (offset == OFF_LAST) begin
                            offset   <= '0;
                            row_base <= row_base - ROW_STEP;
                        end else begin
                            offset <= offset + ADDR_W'(1);
                        end
                    end
                end
                S_CAP: begin
                    acc <= acc_cap;
                    nb  <= nb_cap;
                end
                S_EMIT: begin
                    if (msg_ready) begin
                        acc      <= {8'b0, acc[10:8]};
                        nb       <= nb - 4'd8;
                        byte_cnt <= byte_cnt + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsb_extract_ctrl.sv
// tb/tb_lsb_extract_ctrl.sv - directed self-checking bench for lsb_extract_ctrl on a 4x2 image
module tb_lsb_extract_ctrl;

    localparam int W = 4;
    localparam int H = 2;
    localparam int NPIX = 3 * W * H;

    logic        clk = 1'b0;
    logic        HRESETn;
    logic        start;
    logic        abort;
    logic [15:0] msg_len;
    logic        mem_rd_en;
    logic [19:0] mem_addr;
    logic [7:0]  mem_rd_data;
    logic [7:0]  msg_data;
    logic        msg_valid;
    logic        msg_ready;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] mem [0:NPIX-1];
    int         rd_log[$];
    logic [7:0] msg_log[$];
    int         done_cnt = 0;
    logic       err_at_done = 1'b0;
    int         rd_while_valid = 0;

    always #5 clk = ~clk;

    lsb_extract_ctrl #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(20), .LEN_W(16)
    ) dut (
        .clk(clk), .HRESETn(HRESETn), .start(start), .abort(abort),
        .msg_len(msg_len), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .msg_data(msg_data), .msg_valid(msg_valid),
        .msg_ready(msg_ready), .busy(busy), .done(done), .err(err)
    );

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= (mem_addr < NPIX) ? mem[mem_addr] : 8'hxx;
    end

    always @(negedge clk) begin
        if (mem_rd_en) rd_log.push_back(int'(mem_addr));
        if (mem_rd_en && msg_valid) rd_while_valid++;
        if (msg_valid && msg_ready) msg_log.push_back(msg_data);
        if (done) begin
            done_cnt++;
            err_at_done = err;
        end
    end

    function automatic int exp_addr(int p);
        return 3 * W * (H - 1 - p / (3 * W)) + p % (3 * W);
    endfunction

    function automatic logic [7:0] exp_byte(int x);
        logic [7:0] r;
        logic [7:0] d;
        for (int b = 0; b < 8; b++) begin
            d    = mem[exp_addr((8 * x + b) / 3)];
            r[b] = d[(8 * x + b) % 3];
        end
        return r;
    endfunction

    task automatic start_run(input int len);
        @(posedge clk); #1;
        msg_len = 16'(len);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        msg_len = 16'hFFFF;
    endtask

    task automatic wait_done(input int d0, output bit timed_out, output int cycles);
        timed_out = 1'b1;
        cycles    = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            cycles++;
            if (done_cnt > d0) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_run(input int len, output bit timed_out);
        int d0;
        int cyc;
        rd_log.delete();
        msg_log.delete();
        rd_while_valid = 0;
        d0 = done_cnt;
        start_run(len);
        wait_done(d0, timed_out, cyc);
    endtask

    task automatic test_reset;
        total_cnt++;
        if ({busy, msg_valid, mem_rd_en, done, err} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {busy, msg_valid, mem_rd_en, done, err});
        else pass_cnt++;
        total_cnt++;
        if ({mem_addr, msg_data} !== 28'h0)
            $display("FAIL reset_data: got addr=%0h data=%0h expected 0/0", mem_addr, msg_data);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        bit to;
        int bad;
        int d0;
        d0 = done_cnt;
        do_run(2, to);
        total_cnt++;
        if (to) $display("FAIL basic_timeout: done never seen"); else pass_cnt++;
        total_cnt++;
        if (rd_log.size() !== 6) $display("FAIL basic_nreads: got %0d expected 6", rd_log.size());
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 6 && i < rd_log.size(); i++)
            if (rd_log[i] !== 12 + i) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL basic_addr_order: %0d addresses wrong, expected 12..17", bad);
        else pass_cnt++;
        total_cnt++;
        if (msg_log.size() !== 2 || msg_log[0] !== 8'h48 || msg_log[1] !== 8'h69)
            $display("FAIL basic_bytes: got n=%0d first=%0h expected 48,69", msg_log.size(),
                     (msg_log.size() > 0) ? msg_log[0] : 8'h00);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt - d0 !== 1 || err_at_done !== 1'b0)
            $display("FAIL basic_done: got pulses=%0d err=%b expected 1/0", done_cnt - d0, err_at_done);
        else pass_cnt++;
    endtask

    task automatic test_stall;
        bit to;
        int bad;
        int d0;
        int cyc;
        bit seen;
        rd_log.delete();
        msg_log.delete();
        rd_while_valid = 0;
        msg_ready = 1'b0;
        d0 = done_cnt;
        start_run(2);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (msg_valid) seen = 1'b1;
        end
        total_cnt++;
        if (!seen) $display("FAIL stall_valid_timeout: msg_valid never rose"); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (msg_valid !== 1'b1 || msg_data !== 8'h48 || mem_rd_en !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL stall_hold: %0d stalled cycles lost valid/data 48 or read", bad);
        else pass_cnt++;
        @(posedge clk); #1;
        msg_ready = 1'b1;
        wait_done(d0, to, cyc);
        total_cnt++;
        if (to || msg_log.size() !== 2 || msg_log[0] !== 8'h48 || msg_log[1] !== 8'h69)
            $display("FAIL stall_bytes: got n=%0d timeout=%0b expected 48,69", msg_log.size(), to);
        else pass_cnt++;
        total_cnt++;
        if (rd_log.size() !== 6 || rd_while_valid !== 0)
            $display("FAIL stall_reads: got %0d reads, %0d during valid, expected 6/0", rd_log.size(), rd_while_valid);
        else pass_cnt++;
    endtask

    task automatic test_row_wrap;
        bit to;
        int bad;
        do_run(5, to);
        total_cnt++;
        if (to || rd_log.size() !== 14)
            $display("FAIL wrap_nreads: got %0d timeout=%0b expected 14", rd_log.size(), to);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 14 && i < rd_log.size(); i++)
            if (rd_log[i] !== exp_addr(i)) bad++;
        total_cnt++;
        if (bad != 0 || rd_log.size() < 14 || rd_log[12] !== 0 || rd_log[13] !== 1)
            $display("FAIL wrap_addr_order: %0d wrong, expected 12..23,0,1", bad);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 5; i++)
            if (i >= msg_log.size() || msg_log[i] !== exp_byte(i)) bad++;
        total_cnt++;
        if (bad != 0 || msg_log.size() !== 5)
            $display("FAIL wrap_bytes: got n=%0d with %0d wrong, expected 5 correct", msg_log.size(), bad);
        else pass_cnt++;
    endtask

    task automatic test_capacity;
        bit to;
        int bad;
        do_run(9, to);
        bad = 0;
        for (int i = 0; i < 9; i++)
            if (i >= msg_log.size() || msg_log[i] !== exp_byte(i)) bad++;
        total_cnt++;
        if (to || rd_log.size() !== 24 || msg_log.size() !== 9 || bad != 0 || err_at_done !== 1'b0)
            $display("FAIL cap9: got reads=%0d bytes=%0d bad=%0d err=%b expected 24/9/0/0",
                     rd_log.size(), msg_log.size(), bad, err_at_done);
        else pass_cnt++;
        do_run(10, to);
        bad = 0;
        for (int i = 0; i < 9; i++)
            if (i >= msg_log.size() || msg_log[i] !== exp_byte(i)) bad++;
        total_cnt++;
        if (to || rd_log.size() !== 24 || msg_log.size() !== 9 || bad != 0)
            $display("FAIL cap10_stream: got reads=%0d bytes=%0d bad=%0d expected 24/9/0",
                     rd_log.size(), msg_log.size(), bad);
        else pass_cnt++;
        total_cnt++;
        if (err_at_done !== 1'b1 || err !== 1'b1 || busy !== 1'b0)
            $display("FAIL cap10_err: got err_at_done=%b err=%b busy=%b expected 1/1/0", err_at_done, err, busy);
        else pass_cnt++;
        do_run(1, to);
        total_cnt++;
        if (to || err !== 1'b0 || msg_log.size() !== 1 || msg_log[0] !== exp_byte(0) || rd_log.size() !== 3)
            $display("FAIL err_clear: got err=%b bytes=%0d reads=%0d expected 0/1/3", err, msg_log.size(), rd_log.size());
        else pass_cnt++;
    endtask

    task automatic test_zero_len;
        bit to;
        int d0;
        int cyc;
        rd_log.delete();
        msg_log.delete();
        d0 = done_cnt;
        start_run(0);
        wait_done(d0, to, cyc);
        total_cnt++;
        if (to || cyc > 2)
            $display("FAIL zero_len_done: got %0d cycles timeout=%0b expected done within 2", cyc, to);
        else pass_cnt++;
        total_cnt++;
        if (rd_log.size() !== 0 || msg_log.size() !== 0 || done_cnt - d0 !== 1)
            $display("FAIL zero_len_activity: got reads=%0d bytes=%0d pulses=%0d expected 0/0/1",
                     rd_log.size(), msg_log.size(), done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored;
        bit to;
        int d0;
        int cyc;
        rd_log.delete();
        msg_log.delete();
        d0 = done_cnt;
        start_run(2);
        repeat (3) @(posedge clk);
        #1;
        start   = 1'b1;
        msg_len = 16'd5;
        @(posedge clk); #1;
        start   = 1'b0;
        wait_done(d0, to, cyc);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (to || rd_log.size() !== 6 || msg_log.size() !== 2 || done_cnt - d0 !== 1 || busy !== 1'b0)
            $display("FAIL start_ignored: got reads=%0d bytes=%0d pulses=%0d busy=%b expected 6/2/1/0",
                     rd_log.size(), msg_log.size(), done_cnt - d0, busy);
        else pass_cnt++;
    endtask

    task automatic test_abort;
        bit to;
        int d0;
        int nrd;
        rd_log.delete();
        msg_log.delete();
        d0 = done_cnt;
        start_run(2);
        nrd = 0;
        for (int i = 0; i < 100 && nrd < 2; i++) begin
            @(negedge clk);
            if (mem_rd_en) nrd++;
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total_cnt++;
        if (nrd != 2 || {busy, msg_valid, mem_rd_en} !== 3'b000)
            $display("FAIL abort_idle: got nrd=%0d busy/valid/rd=%b expected 2/000", nrd, {busy, msg_valid, mem_rd_en});
        else pass_cnt++;
        repeat (10) @(negedge clk);
        total_cnt++;
        if (rd_log.size() !== 2 || msg_log.size() !== 0 || done_cnt !== d0)
            $display("FAIL abort_quiet: got reads=%0d bytes=%0d pulses=%0d expected 2/0/0",
                     rd_log.size(), msg_log.size(), done_cnt - d0);
        else pass_cnt++;
        do_run(2, to);
        total_cnt++;
        if (to || msg_log.size() !== 2 || msg_log[0] !== 8'h48 || msg_log[1] !== 8'h69)
            $display("FAIL abort_restart: got n=%0d timeout=%0b expected 48,69", msg_log.size(), to);
        else pass_cnt++;
    endtask

    task automatic test_reset_emit;
        bit to;
        bit seen;
        int d0;
        msg_ready = 1'b0;
        d0 = done_cnt;
        start_run(2);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (msg_valid) seen = 1'b1;
        end
        #2;
        HRESETn = 1'b0;
        #1;
        total_cnt++;
        if (!seen || {busy, msg_valid, mem_rd_en, done} !== 4'b0000)
            $display("FAIL reset_emit_async: got seen=%b busy/valid/rd/done=%b expected 1/0000",
                     seen, {busy, msg_valid, mem_rd_en, done});
        else pass_cnt++;
        @(negedge clk);
        HRESETn   = 1'b1;
        msg_ready = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (done_cnt !== d0 || busy !== 1'b0)
            $display("FAIL reset_emit_quiet: got pulses=%0d busy=%b expected 0/0", done_cnt - d0, busy);
        else pass_cnt++;
        do_run(2, to);
        total_cnt++;
        if (to || msg_log.size() !== 2 || msg_log[0] !== 8'h48 || msg_log[1] !== 8'h69)
            $display("FAIL reset_restart: got n=%0d timeout=%0b expected 48,69", msg_log.size(), to);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = 8'((i * 37 + 5) & 8'hFF);
        mem[12] = 8'hF8; mem[13] = 8'h21; mem[14] = 8'h75;
        mem[15] = 8'hAC; mem[16] = 8'h36; mem[17] = 8'h10;
        mem_rd_data = 8'h00;
        HRESETn   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        msg_len   = 16'd0;
        msg_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        HRESETn = 1'b1;
        repeat (2) @(negedge clk);
        test_reset;
        test_basic;
        test_stall;
        test_row_wrap;
        test_capacity;
        test_zero_len;
        test_start_ignored;
        test_abort;
        test_reset_emit;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lsb_extract_ctrl.md
Name: lsb_extract_ctrl

Overview:
Sequencer for LSB-steganography message extraction from a stego image held in a byte-wide pixel memory. On start it walks the pixel bytes in display raster order, with rows stored bottom-up in memory. It takes bits [2:0] of each byte and packs them LSB-first into message bytes. Each byte is emitted on a valid/ready stream toward the file-writer/UART sink. It replaces the fixed one-shot extraction loop with a restartable, backpressure-aware controller that owns the memory read port.

Parameters:
WIDTH, 500, image width in pixels
HEIGHT, 332, image height in pixels
ADDR_W, 20, pixel memory address width (must hold WIDTH*HEIGHT*3-1)
LEN_W, 16, width of message length / byte counters

Ports:
clk  in  1  system clock, rising edge
HRESETn  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin extraction; ignored unless idle
abort  in  1  cancel the current extraction; return to IDLE
msg_len  in  LEN_W  number of message bytes to extract; sampled on accepted start
mem_rd_en  out  1  pixel memory read strobe
mem_addr  out  ADDR_W  pixel memory byte address
mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
msg_data  out  8  extracted message byte
msg_valid  out  1  msg_data valid; held until accepted
msg_ready  in  1  sink accepts byte when msg_valid&&msg_ready
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of run (normal or overflow)
err  out  1  capacity overflow flag; cleared by the next accepted start

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs 0; accumulator, bit count, byte count and address registers cleared.
- Address order: pixel byte index p runs 0..WIDTH*HEIGHT*3-1.
  - row r = p/(3*WIDTH) and offset o = p%(3*WIDTH).
  - mem_addr = 3*WIDTH*(HEIGHT-1-r) + o.
  - Implement with a row_base register, starting at 3*WIDTH*(HEIGHT-1), and an offset counter. When the offset wraps, row_base is decremented by 3*WIDTH. No multipliers.
- Bit packing:
  - Accumulator acc[10:0] and bit count nb (0..10).
  - On each captured byte d: acc |= d[2:0] << nb; nb += 3.
  - Message bit k = bit (k%3) of pixel byte k/3. Message byte x bit b = message bit 8x+b.
- FSM states and transitions:
  - IDLE: on start, clear err, latch msg_len.
    - If msg_len==0, go to FIN.
    - Otherwise clear acc, nb, byte count and p, then go to RD.
  - RD: if p == WIDTH*HEIGHT*3, set err and go to FIN. Otherwise mem_rd_en=1 with mem_addr(p) for one cycle, p++, go to CAP.
  - CAP: capture mem_rd_data[2:0] into acc. If nb_new >= 8 go to EMIT, else go to RD.
  - EMIT: msg_valid=1, msg_data=acc[7:0], held stable until msg_ready. On handshake: acc >>= 8, nb -= 8, byte_cnt++. If byte_cnt_new == latched len go to FIN, else go to RD.
  - FIN: done=1 for one cycle, go to IDLE.
- Throughput: 2 cycles per pixel byte, plus 1 EMIT cycle per message byte when msg_ready is high.
- Leftover bits: accumulator bits remaining after the final byte are discarded. Total reads = ceil(8*len/3).
- Boundary conditions:
  - abort has priority in every state: go to IDLE next cycle, no done pulse, msg_valid drops, no further reads. err is unchanged.
  - start while busy is ignored. msg_len changes during a run have no effect.
  - Capacity overflow: bytes already emitted stay valid, err=1 together with the done pulse, and busy drops after FIN.
  - msg_ready asserted outside EMIT has no effect.
- At most one read is outstanding at any time. mem_rd_en is never asserted in CAP, EMIT, FIN or IDLE.

Test Plan:
- Params WIDTH=4, HEIGHT=2; memory bytes 12..17 = 0xF8,0x21,0x75,0xAC,0x36,0x10; start, msg_len=2, msg_ready=1 -> reads at 12,13,14,15,16,17 in that order; msg bytes 0x48 then 0x69; done pulse; err=0; no read after address 17.
- Same run with msg_ready low for 5 cycles at the first EMIT -> msg_valid/msg_data=0x48 held stable for all 5 cycles; no mem_rd_en while stalled; output sequence unchanged.
- msg_len=5 -> 14 reads in order 12..23, 0, 1 (row wrap); exactly 5 bytes emitted; done pulse.
- msg_len=9 -> 24 reads, 9 bytes, err=0. msg_len=10 -> 24 reads, 9 bytes, then done with err=1; next start with msg_len=1 clears err.
- msg_len=0 -> done pulse 2 cycles after start, zero reads, zero bytes. A second start during a msg_len=2 run is ignored.
- abort asserted during the 2nd CAP, and separately HRESETn pulsed low mid-EMIT -> IDLE; msg_valid, busy and mem_rd_en=0 immediately (async for reset); no done pulse; a fresh start then reproduces 0x48, 0x69.
